// File: rtl/pc_gen_if.sv
// Fetch-PC control bundle: pipeline steering inputs and predecode hints in, fetch PC and RAS status out.
// The pipeline side drives the master modport; pc_gen sits on the slave modport.
interface pc_gen_if #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
);
    logic                         stall;
    logic                         trap_valid;
    logic [XLEN-1:0]              trap_vec;
    logic                         redirect;
    logic [XLEN-1:0]              redirect_pc;
    logic                         is_call;
    logic                         is_ret;
    logic [XLEN-1:0]              pc_out;
    logic                         misalign_err;
    logic [$clog2(RAS_DEPTH):0]   ras_count;

    modport master (
        output stall, trap_valid, trap_vec, redirect, redirect_pc, is_call, is_ret,
        input  pc_out, misalign_err, ras_count
    );

    modport slave (
        input  stall, trap_valid, trap_vec, redirect, redirect_pc, is_call, is_ret,
        output pc_out, misalign_err, ras_count
    );
endinterface

// File: rtl/pc_gen.sv
// Next-fetch-PC generator with a circular return-address stack; one-cycle registered PC.
// Stall freezes PC and RAS; trap and redirect always win and never touch the RAS.
module pc_gen #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              RAS_DEPTH = 4
) (
    input  logic   clk,
    input  logic   nrst,
    pc_gen_if.slave bus
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    typedef logic [XLEN-1:0] addr_t;

    addr_t          pc_q, pc_d;
    logic           misalign_q, misalign_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [PW-1:0]  top_q, top_d;
    addr_t          ras_q [RAS_DEPTH];
    addr_t          ras_d [RAS_DEPTH];

    addr_t          pc_seq;
    addr_t          trap_pc;
    addr_t          redir_pc;
    logic [PW-1:0]  top_inc;
    logic           ras_empty;
    logic           ras_full;
    logic           advance;

    always_comb begin
        pc_seq    = pc_q + addr_t'(4);
        trap_pc   = bus.trap_vec & ~addr_t'(3);
        redir_pc  = bus.redirect_pc & ~addr_t'(3);
        top_inc   = top_q + PW'(1);
        ras_empty = (cnt_q == '0);
        ras_full  = (cnt_q == CW'(RAS_DEPTH));
        advance   = !bus.trap_valid && !bus.redirect && !bus.stall;

        pc_d       = pc_q;
        misalign_d = 1'b0;
        cnt_d      = cnt_q;
        top_d      = top_q;
        ras_d      = ras_q;

        if (bus.trap_valid) begin
            pc_d = trap_pc;
        end else if (bus.redirect) begin
            pc_d       = redir_pc;
            misalign_d = (bus.redirect_pc[1:0] != 2'b00);
        end else if (advance) begin
            if (bus.is_ret && !ras_empty) begin
                pc_d = ras_q[top_q];
                // Call+return swaps the top in place, so depth is unchanged.
                if (bus.is_call) begin
                    ras_d[top_q] = pc_seq;
                end else begin
                    top_d = top_q - PW'(1);
                    cnt_d = cnt_q - CW'(1);
                end
            end else begin
                pc_d = pc_seq;
                // When full, top_inc already points at the oldest entry.
                if (bus.is_call) begin
                    ras_d[top_inc] = pc_seq;
                    top_d          = top_inc;
                    if (!ras_full) begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
            cnt_q      <= '0;
            top_q      <= '0;
        end else begin
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
            cnt_q      <= cnt_d;
            top_q      <= top_d;
        end
    end

    // Stack storage is left unreset; a zero count hides stale entries.
    always_ff @(posedge clk) begin
        ras_q <= ras_d;
    end

    assign bus.pc_out       = pc_q;
    assign bus.misalign_err = misalign_q;
    assign bus.ras_count    = cnt_q;

endmodule

// File: tb/tb_pc_gen.sv
// Drives a 32-bit/depth-4 and a 64-bit/depth-8 pc_gen with identical stimulus and
// checks both against a list-based reference model plus literal expectations.
module tb_pc_gen;
    localparam logic [63:0] RST_A = 64'h0;
    localparam logic [63:0] RST_B = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        nrst;
    logic        stall, trap_valid, redirect, is_call, is_ret;
    logic [63:0] trap_vec, redirect_pc;

    always #5 clk = ~clk;

    pc_gen_if #(.XLEN(32), .RAS_DEPTH(4)) bus_a ();
    pc_gen_if #(.XLEN(64), .RAS_DEPTH(8)) bus_b ();

    assign bus_a.stall       = stall;
    assign bus_a.trap_valid  = trap_valid;
    assign bus_a.trap_vec    = trap_vec[31:0];
    assign bus_a.redirect    = redirect;
    assign bus_a.redirect_pc = redirect_pc[31:0];
    assign bus_a.is_call     = is_call;
    assign bus_a.is_ret      = is_ret;

    assign bus_b.stall       = stall;
    assign bus_b.trap_valid  = trap_valid;
    assign bus_b.trap_vec    = trap_vec;
    assign bus_b.redirect    = redirect;
    assign bus_b.redirect_pc = redirect_pc;
    assign bus_b.is_call     = is_call;
    assign bus_b.is_ret      = is_ret;

    pc_gen #(.XLEN(32), .RESET_PC(RST_A[31:0]), .RAS_DEPTH(4)) dut_a (
        .clk (clk),
        .nrst(nrst),
        .bus (bus_a)
    );

    pc_gen #(.XLEN(64), .RESET_PC(RST_B), .RAS_DEPTH(8)) dut_b (
        .clk (clk),
        .nrst(nrst),
        .bus (bus_b)
    );

    // Reference model: per-DUT PC, error flag and a plain list stack (index 0 = oldest).
    logic [63:0] m_pc  [2];
    bit          m_mis [2];
    logic [63:0] m_stk [2][16];
    int          m_sz  [2];
    bit          chk_en = 1'b0;

    int total = 0;
    int bad   = 0;

    // Literal expectation checked at the next compare point.
    bit          lit_en = 1'b0;
    int          lit_dut;
    string       lit_name;
    logic [63:0] lit_pc, lit_cnt;
    bit          lit_mis;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin : compare_proc
        logic [63:0] mk, seq, tgt, rpc;
        int          dep;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                mk  = (i == 0) ? 64'hFFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
                dep = (i == 0) ? 4 : 8;
                seq = (m_pc[i] + 64'd4) & mk;
                if (!nrst) begin
                    m_pc[i]  = (i == 0) ? RST_A : RST_B;
                    m_mis[i] = 1'b0;
                    m_sz[i]  = 0;
                end else if (trap_valid) begin
                    m_pc[i]  = trap_vec & mk & ~64'h3;
                    m_mis[i] = 1'b0;
                end else if (redirect) begin
                    rpc      = redirect_pc & mk;
                    m_pc[i]  = rpc & ~64'h3;
                    m_mis[i] = (rpc[1:0] != 2'b00);
                end else begin
                    m_mis[i] = 1'b0;
                    if (!stall) begin
                        if (is_ret && m_sz[i] > 0) begin
                            tgt = m_stk[i][m_sz[i]-1];
                            if (is_call) m_stk[i][m_sz[i]-1] = seq;
                            else         m_sz[i]--;
                            m_pc[i] = tgt;
                        end else begin
                            if (is_call) begin
                                if (m_sz[i] == dep) begin
                                    for (int k = 0; k < 15; k++) m_stk[i][k] = m_stk[i][k+1];
                                    m_sz[i]--;
                                end
                                m_stk[i][m_sz[i]] = seq;
                                m_sz[i]++;
                            end
                            m_pc[i] = seq;
                        end
                    end
                end
            end
            if (!nrst) chk_en = 1'b1;
            if (chk_en) begin
                chk("pc_a",  64'(bus_a.pc_out),       m_pc[0]);
                chk("mis_a", 64'(bus_a.misalign_err), 64'(m_mis[0]));
                chk("cnt_a", 64'(bus_a.ras_count),    64'(m_sz[0]));
                chk("pc_b",  bus_b.pc_out,            m_pc[1]);
                chk("mis_b", 64'(bus_b.misalign_err), 64'(m_mis[1]));
                chk("cnt_b", 64'(bus_b.ras_count),    64'(m_sz[1]));
            end
            if (lit_en) begin
                if (lit_dut == 0) begin
                    chk({lit_name, "_pc"},  64'(bus_a.pc_out),       lit_pc);
                    chk({lit_name, "_cnt"}, 64'(bus_a.ras_count),    lit_cnt);
                    chk({lit_name, "_mis"}, 64'(bus_a.misalign_err), 64'(lit_mis));
                end else begin
                    chk({lit_name, "_pc"},  bus_b.pc_out,            lit_pc);
                    chk({lit_name, "_cnt"}, 64'(bus_b.ras_count),    lit_cnt);
                    chk({lit_name, "_mis"}, 64'(bus_b.misalign_err), 64'(lit_mis));
                end
            end
        end
    end

    task automatic set_in(input logic tr, input logic [63:0] tv, input logic rd,
                          input logic [63:0] rp, input logic st, input logic c, input logic r);
        trap_valid  = tr;
        trap_vec    = tv;
        redirect    = rd;
        redirect_pc = rp;
        stall       = st;
        is_call     = c;
        is_ret      = r;
    endtask

    task automatic expect_out(input int d, input string nm, input logic [63:0] pc,
                              input logic [63:0] cnt, input bit mis);
        lit_dut  = d;
        lit_name = nm;
        lit_pc   = pc;
        lit_cnt  = cnt;
        lit_mis  = mis;
        lit_en   = 1'b1;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
        lit_en = 1'b0;
    endtask

    initial begin : main_proc
        logic [63:0] ret_exp [4];
        ret_exp = '{64'h54, 64'h44, 64'h34, 64'h24};

        nrst = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0);
        expect_out(0, "reset", 64'h0, 0, 0);
        tick();
        nrst = 1'b1;

        for (int k = 1; k <= 3; k++) begin
            expect_out(0, "idle", 64'(4 * k), 0, 0);
            tick();
        end

        set_in(0, 0, 1, 64'h100, 0, 0, 0); expect_out(0, "redir100", 64'h100, 0, 0); tick();
        set_in(0, 0, 0, 0, 1, 0, 0);       expect_out(0, "stall",    64'h100, 0, 0); tick();
        set_in(0, 0, 1, 64'h200, 1, 0, 0); expect_out(0, "stall_rd", 64'h200, 0, 0); tick();

        set_in(0, 0, 1, 64'h203, 0, 0, 0); expect_out(0, "misal",    64'h200, 0, 1); tick();
        set_in(0, 0, 0, 0, 0, 0, 0);       expect_out(0, "misal_end", 64'h204, 0, 0); tick();
        set_in(1, 64'h80, 1, 64'h300, 0, 0, 0); expect_out(0, "trap_win", 64'h80, 0, 0); tick();

        for (int k = 1; k <= 5; k++) begin
            set_in(0, 0, 1, 64'(16 * k), 0, 0, 0); tick();
            set_in(0, 0, 0, 0, 0, 1, 0);
            expect_out(0, "call", 64'(16 * k + 4), 64'((k > 4) ? 4 : k), 0);
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            set_in(0, 0, 0, 0, 0, 0, 1);
            expect_out(0, "ret", ret_exp[k], 64'(3 - k), 0);
            tick();
        end
        expect_out(0, "ret_empty", 64'h28, 0, 0); tick();

        set_in(0, 0, 1, 64'h10, 0, 0, 0); tick();
        set_in(0, 0, 0, 0, 0, 1, 0);      expect_out(0, "call14", 64'h14, 1, 0); tick();
        set_in(0, 0, 1, 64'h60, 0, 0, 0); tick();
        set_in(0, 0, 0, 0, 0, 1, 1);      expect_out(0, "callret", 64'h14, 1, 0); tick();
        set_in(0, 0, 0, 0, 0, 0, 1);      expect_out(0, "newtop", 64'h64, 0, 0); tick();

        set_in(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0);
        expect_out(1, "b_top", 64'hFFFF_FFFF_FFFF_FFFC, 0, 0); tick();
        set_in(0, 0, 0, 0, 0, 0, 0);
        expect_out(1, "b_wrap", 64'h0, 0, 0); tick();
        for (int k = 1; k <= 8; k++) begin
            set_in(0, 0, 0, 0, 0, 1, 0);
            expect_out(1, "b_fill", 64'(4 * k), 64'(k), 0);
            tick();
        end
        nrst = 1'b0;
        set_in(1, 64'h40, 1, 64'h123, 1, 1, 0);
        expect_out(1, "b_rst", RST_B, 0, 0); tick();
        expect_out(0, "a_rst", RST_A, 0, 0); tick();
        nrst = 1'b1;

        for (int n = 0; n < 3000; n++) begin
            nrst = ($urandom_range(99) != 0);
            set_in(($urandom_range(19) == 0), {$urandom, $urandom},
                   ($urandom_range(9) == 0),  {$urandom, $urandom},
                   ($urandom_range(5) == 0),
                   ($urandom_range(3) == 0),  ($urandom_range(2) == 0));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter XLEN, 32, PC and address width; legal values are 32 and 64.
REQ-002 Parameter RESET_PC, 0, value loaded into pc_out on reset; XLEN bits wide, with bits [1:0] equal to 0.
REQ-003 Parameter RAS_DEPTH, 4, return-address-stack entries; a power of two, range 2..16.
REQ-004 Clock and reset: clk; reset nrst, synchronous, active-low.
REQ-005 Port clk  in  1  rising-edge clock.
REQ-006 Port nrst  in  1  synchronous active-low reset.
REQ-007 Port stall  in  1  hold the current PC; suppresses prediction and sequential advance.
REQ-008 Port trap_valid  in  1  exception or interrupt taken.
REQ-009 Port trap_vec  in  XLEN  trap handler address.
REQ-010 Port redirect  in  1  resolved branch, jump or mispredict correction from EX.
REQ-011 Port redirect_pc  in  XLEN  correction target.
REQ-012 Port is_call  in  1  predecode: the instruction at pc_out is a call.
REQ-013 Port is_ret  in  1  predecode: the instruction at pc_out is a return.
REQ-014 Port pc_out  out  XLEN  current fetch PC, registered.
REQ-015 Port misalign_err  out  1  one-cycle pulse: the last redirect target had bits [1:0] not equal to 0.
REQ-016 Port ras_count  out  $clog2(RAS_DEPTH)+1  number of valid RAS entries.

Function
REQ-017 Next-PC priority SHALL be: reset > trap_valid > redirect > stall > is_ret with a non-empty RAS > sequential.
- Sequential means pc_out + 4, computed modulo 2^XLEN.
- Wrap from all-ones-minus-3 to 0 is silent.
REQ-018 When trap_valid=1, pc_out SHALL load {trap_vec[XLEN-1:2], 2'b00} on the next edge, regardless of stall and redirect.
REQ-019 When redirect=1 and trap_valid=0, pc_out SHALL load {redirect_pc[XLEN-1:2], 2'b00} on the next edge, regardless of stall.
REQ-020 In a redirect cycle, misalign_err SHALL be set to (redirect_pc[1:0]!=0) on the same edge that loads pc_out; it SHALL be 0 in every other cycle.
REQ-021 When stall=1 and neither trap_valid nor redirect is asserted:
- pc_out, the RAS contents and ras_count SHALL hold.
- is_call and is_ret SHALL be ignored.
REQ-022 RAS push: is_call=1 with no trap, redirect or stall SHALL write pc_out+4 at the top of the stack.
REQ-023 RAS pop: is_ret=1 with no trap, redirect or stall and ras_count>0 SHALL:
- load pc_out with the top entry;
- remove that entry from the stack.
REQ-024 The RAS SHALL be a circular buffer with a top pointer that wraps modulo RAS_DEPTH.
REQ-025 Push when full (ras_count=RAS_DEPTH) SHALL overwrite the oldest entry; ras_count stays at RAS_DEPTH.
REQ-026 Pop when empty (ras_count=0) SHALL make no prediction: pc_out takes pc_out+4 and ras_count stays 0.
REQ-027 When is_call and is_ret are both 1 with a non-empty RAS:
- pc_out SHALL load the old top entry;
- the top entry SHALL be replaced by pc_out+4;
- ras_count SHALL be unchanged.
REQ-028 When is_call and is_ret are both 1 with an empty RAS, the behaviour SHALL equal a plain push.
REQ-029 Trap and redirect cycles SHALL leave RAS contents and ras_count unchanged; there is no speculative RAS repair.
REQ-030 The predicted-call target SHALL be supplied later through redirect; pc_gen itself SHALL advance sequentially on a call.

Reset
REQ-031 While nrst=0 at a rising edge, the block SHALL set:
- pc_out = RESET_PC;
- misalign_err = 0;
- ras_count = 0;
- the top pointer = 0.
REQ-032 Reset SHALL override all other inputs, including while trap_valid, redirect or stall is asserted.
REQ-033 RAS storage needs no reset; ras_count=0 makes stale entries unreachable.

Verification
REQ-034 Reset, then 3 idle cycles -> pc_out = 0x0, 0x4, 0x8, 0xC; ras_count=0.
REQ-035 pc_out=0x100, stall=1 held for 2 cycles with redirect=1 (redirect_pc=0x200) in the second cycle:
- pc_out holds 0x100 for the first cycle;
- pc_out then loads 0x200;
- misalign_err=0.
REQ-036 Redirect to 0x203 -> pc_out=0x200 and misalign_err=1 for exactly one cycle; trap_valid=1 (trap_vec=0x80) together with redirect=1 -> pc_out=0x80.
REQ-037 RAS_DEPTH=4, call at each of 0x10, 0x20, 0x30, 0x40, 0x50, then 5 returns:
- the first 4 returns predict 0x54, 0x44, 0x34, 0x24;
- the 5th return advances by +4;
- ras_count goes 4 -> 0.
REQ-038 Simultaneous is_call and is_ret at pc_out=0x60 with top entry 0x14 -> pc_out=0x14, new top=0x64, ras_count unchanged.
REQ-039 XLEN=64, pc_out=0xFFFF_FFFF_FFFF_FFFC, idle -> pc_out=0x0; nrst=0 asserted while RAS is full -> ras_count=0 and pc_out=RESET_PC on the next edge.
